hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage ARM pipeline (IF/DEC/EX/MEM/WR).
- Sequences pipeline-register enables, bubble insertion and IF flush for three cases: load-use hazards, multi-cycle MUL/SDIV occupancy of EX, and taken branches resolved in DEC.
- Complements the forwarding unit: it stalls only where forwarding cannot cover the hazard.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, total EX cycles for MUL (must be >=1)
DIV_LAT, 16, total EX cycles for SDIV (must be >=1)
CNT_W, 5, busy counter width (must hold max(MUL_LAT,DIV_LAT)-2)
PERF_W, 32, stall performance counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
Rn_DEC  input  5  Rn field of instruction in DEC
Rm_DEC  input  5  Rm field of instruction in DEC
Rd_DEC  input  5  Rd/Rt field of instruction in DEC
UsesRn_DEC  input  1  DEC instruction reads Rn
UsesRm_DEC  input  1  DEC instruction reads Rm (R-type)
UsesRd_DEC  input  1  DEC instruction reads Rd as a source (STUR, STURB, CBZ, CBNZ, BR)
MultiCycle_DEC  input  1  DEC instruction is MUL or SDIV
IsDiv_DEC  input  1  1 = SDIV, 0 = MUL (valid with MultiCycle_DEC)
BrTaken_DEC  input  1  branch in DEC resolved taken this cycle
Rd_EX  input  5  destination register in EX
RegWrite_EX  input  1  EX instruction writes the register file
MemRead_EX  input  1  EX instruction is LDUR/LDURB
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/DEC register enable
IDEXWrite  output  1  DEC/EX register enable
IDEXBubble  output  1  load NOP (all control 0) into DEC/EX
EXMEMBubble  output  1  load NOP into EX/MEM
IFIDFlush  output  1  replace IF/DEC contents with NOP
Busy  output  1  multi-cycle unit occupied
StallCycles  output  PERF_W  count of stalled cycles

Behaviour:
- FSM states: RUN, MCBUSY. Busy counter Cnt is CNT_W bits.
- Reset (synchronous): on the next edge, state <= RUN, Cnt <= 0, StallCycles <= 0.
- Outputs in RUN with no hazard: PCWrite = IFIDWrite = IDEXWrite = 1; all bubbles, flush and Busy = 0.
- Outputs while reset is asserted: same as RUN with no hazard.
- Load-use hazard (LU), combinational, evaluated in RUN only. LU = MemRead_EX & RegWrite_EX & Rd_EX != 31 & any of:
  - UsesRn_DEC & Rn_DEC == Rd_EX
  - UsesRm_DEC & Rm_DEC == Rd_EX
  - UsesRd_DEC & Rd_DEC == Rd_EX
- LU response: PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1, for exactly 1 cycle. In the next cycle the load is in MEM and the forwarding unit covers it.
- Multi-cycle issue: in RUN with MultiCycle_DEC = 1, !LU and LAT >= 2, where LAT = IsDiv_DEC ? DIV_LAT : MUL_LAT. The instruction advances to EX at the edge; state <= MCBUSY, Cnt <= LAT-2.
- LAT = 1: no state change; the instruction is treated as single-cycle.
- MCBUSY outputs: PCWrite = IFIDWrite = IDEXWrite = 0, EXMEMBubble = 1, Busy = 1. IDEXBubble = 0 and IFIDFlush = 0.
- MCBUSY transitions: Cnt == 0 -> RUN; otherwise Cnt <= Cnt-1. Total stall = LAT-1 cycles. The result leaves EX on the first RUN cycle.
- Priority: MCBUSY > LU > BrTaken_DEC.
- BrTaken_DEC in RUN with !LU: IFIDFlush = 1 for that cycle, with all enables at 1.
- BrTaken_DEC during MCBUSY or LU is ignored; DEC re-asserts it once unstalled.
- LU and MultiCycle_DEC together: LU stall first; issue occurs the following cycle.
- Back-to-back MUL/SDIV: the second is evaluated in the first RUN cycle after busy and may immediately re-enter MCBUSY.
- StallCycles increments by 1 on any cycle with PCWrite = 0 and !reset. It saturates at all-ones (no wrap).
- Reset asserted during MCBUSY: aborts to RUN at the next edge and Cnt is cleared.

Decomposition:
- Shared package cpu_pkg: hazard_state_t enum {RUN, MCBUSY}, REG_ZR = 5'd31, default MUL_LAT/DIV_LAT constants.
- One sub-module: sat_counter (PERF_W-wide saturating incrementer with sync reset), used for StallCycles.

Test Plan:
- Load-use: MemRead_EX = 1, RegWrite_EX = 1, Rd_EX = 3, UsesRm_DEC = 1, Rm_DEC = 3 -> one cycle with PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1; StallCycles 0 -> 1; then normal.
- Zero register: same as above but Rd_EX = 31 = Rm_DEC -> no stall, all enables 1.
- MUL, MUL_LAT = 4: MultiCycle_DEC = 1, IsDiv_DEC = 0 -> Busy = 1 and EXMEMBubble = 1 for exactly 3 cycles, then RUN; StallCycles = 3.
- SDIV back-to-back, DIV_LAT = 16: two SDIVs -> 15 busy cycles, 1 RUN cycle, 15 busy cycles; StallCycles = 30.
- Priority: BrTaken_DEC = 1 with LU true -> IFIDFlush = 0 and stall applied. Next cycle BrTaken_DEC = 1, no LU -> IFIDFlush = 1 with PCWrite = 1.
- Reset mid-DIV: assert reset on busy cycle 5 -> next cycle state RUN, Busy = 0, StallCycles = 0; force PERF_W = 4 with 20 stalls -> StallCycles holds 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants for the 5-stage core.
package cpu_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MCBUSY = 1'b1
  } hazard_state_t;

  localparam logic [4:0] REG_ZR = 5'd31;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush sequencing for load-use, multi-cycle MUL/SDIV and taken
// branches, plus a saturating stalled-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 5,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        Rn_DEC,
  input  logic [4:0]        Rm_DEC,
  input  logic [4:0]        Rd_DEC,
  input  logic              UsesRn_DEC,
  input  logic              UsesRm_DEC,
  input  logic              UsesRd_DEC,
  input  logic              MultiCycle_DEC,
  input  logic              IsDiv_DEC,
  input  logic              BrTaken_DEC,
  input  logic [4:0]        Rd_EX,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXWrite,
  output logic              IDEXBubble,
  output logic              EXMEMBubble,
  output logic              IFIDFlush,
  output logic              Busy,
  output logic [PERF_W-1:0] StallCycles
);

  // Busy counter preload is LAT-2 so that MCBUSY lasts exactly LAT-1 cycles.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LAT >= 2) ? (DIV_LAT - 2) : 0);
  localparam bit MUL_MC = (MUL_LAT >= 2);
  localparam bit DIV_MC = (DIV_LAT >= 2);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             lat_multi;

  assign lu = MemRead_EX && RegWrite_EX && (Rd_EX != REG_ZR) &&
              ((UsesRn_DEC && (Rn_DEC == Rd_EX)) ||
               (UsesRm_DEC && (Rm_DEC == Rd_EX)) ||
               (UsesRd_DEC && (Rd_DEC == Rd_EX)));

  assign lat_multi = IsDiv_DEC ? DIV_MC : MUL_MC;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    IFIDFlush   = 1'b0;
    Busy        = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (lu) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end else begin
            IFIDFlush = BrTaken_DEC;
            if (MultiCycle_DEC && lat_multi) begin
              state_d = MCBUSY;
              cnt_d   = IsDiv_DEC ? DIV_CNT : MUL_CNT;
            end
          end
        end
        MCBUSY: begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
          Busy        = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .srst  (reset),
    .inc   (!PCWrite && !reset),
    .count (StallCycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rn, rm, rd;
    logic urn, urm, urd, mc, isdiv, br;
    logic [4:0] rdex;
    logic rwex, mrex;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [6:0] o;
  } vec_t;

  typedef struct {
    string       name;
    logic [6:0]  o;
    logic [31:0] sc;
  } exp_t;

  // {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble, IFIDFlush, Busy}
  localparam logic [6:0] NORM  = 7'b1110000;
  localparam logic [6:0] LUO   = 7'b0011000;
  localparam logic [6:0] BUSYO = 7'b0000101;
  localparam logic [6:0] FLSH  = 7'b1110010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_s = 1'b1;
  logic [4:0] Rn_DEC, Rm_DEC, Rd_DEC, Rd_EX;
  logic UsesRn_DEC, UsesRm_DEC, UsesRd_DEC, MultiCycle_DEC, IsDiv_DEC, BrTaken_DEC;
  logic RegWrite_EX, MemRead_EX;
  logic PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble, IFIDFlush, Busy;
  logic [31:0] StallCycles;
  logic s_pcw, s_ifw, s_idw, s_idb, s_exb, s_fl, s_busy;
  logic [3:0] s_stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(5), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rn_DEC(Rn_DEC), .Rm_DEC(Rm_DEC), .Rd_DEC(Rd_DEC),
    .UsesRn_DEC(UsesRn_DEC), .UsesRm_DEC(UsesRm_DEC), .UsesRd_DEC(UsesRd_DEC),
    .MultiCycle_DEC(MultiCycle_DEC), .IsDiv_DEC(IsDiv_DEC), .BrTaken_DEC(BrTaken_DEC),
    .Rd_EX(Rd_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble), .IFIDFlush(IFIDFlush),
    .Busy(Busy), .StallCycles(StallCycles)
  );

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(5), .PERF_W(4)) dut_s (
    .clk(clk), .reset(rst_s),
    .Rn_DEC(Rn_DEC), .Rm_DEC(Rm_DEC), .Rd_DEC(Rd_DEC),
    .UsesRn_DEC(UsesRn_DEC), .UsesRm_DEC(UsesRm_DEC), .UsesRd_DEC(UsesRd_DEC),
    .MultiCycle_DEC(MultiCycle_DEC), .IsDiv_DEC(IsDiv_DEC), .BrTaken_DEC(BrTaken_DEC),
    .Rd_EX(Rd_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .PCWrite(s_pcw), .IFIDWrite(s_ifw), .IDEXWrite(s_idw),
    .IDEXBubble(s_idb), .EXMEMBubble(s_exb), .IFIDFlush(s_fl),
    .Busy(s_busy), .StallCycles(s_stall)
  );

  function automatic in_t mk(input logic [4:0] rn, rm, rd, input logic urn, urm, urd,
                             input logic mc, isdiv, br, input logic [4:0] rdex,
                             input logic rwex, mrex);
    in_t v;
    v.rn = rn; v.rm = rm; v.rd = rd;
    v.urn = urn; v.urm = urm; v.urd = urd;
    v.mc = mc; v.isdiv = isdiv; v.br = br;
    v.rdex = rdex; v.rwex = rwex; v.mrex = mrex;
    return v;
  endfunction

  task automatic apply(input in_t v, input logic rst);
    reset = rst;
    Rn_DEC = v.rn; Rm_DEC = v.rm; Rd_DEC = v.rd;
    UsesRn_DEC = v.urn; UsesRm_DEC = v.urm; UsesRd_DEC = v.urd;
    MultiCycle_DEC = v.mc; IsDiv_DEC = v.isdiv; BrTaken_DEC = v.br;
    Rd_EX = v.rdex; RegWrite_EX = v.rwex; MemRead_EX = v.mrex;
  endtask

  // Drive one cycle; expected result goes on the scoreboard and is popped
  // when the outputs are sampled on the falling edge.
  task automatic step(input string nm, input in_t v, input logic rst, input logic [6:0] exp);
    exp_t e;
    logic [6:0] act;
    apply(v, rst);
    e.name = nm; e.o = exp; e.sc = exp_stall;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    act = {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble, IFIDFlush, Busy};
    checks++;
    if (act !== e.o) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", e.name, act, e.o);
    end
    checks++;
    if (StallCycles !== e.sc) begin
      errors++;
      $display("FAIL %s StallCycles: got %0d expected %0d", e.name, StallCycles, e.sc);
    end
    $display("txn %-12s rst=%b outs=%b stall=%0d", e.name, rst, act, StallCycles);
    @(posedge clk);
    #1;
    if (rst) exp_stall = 0;
    else if (!exp[6]) exp_stall = exp_stall + 1;
  endtask

  in_t  idle, mulv, divv, luv;
  vec_t tbl[12];

  initial begin
    idle = mk(5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    mulv = mk(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    divv = mk(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    luv  = mk(5'd7, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);

    tbl[0]  = '{"idle",     idle, NORM};
    tbl[1]  = '{"lu_rm",    luv, LUO};
    tbl[2]  = '{"zero_reg", mk(5'd0, 5'd31, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1), NORM};
    tbl[3]  = '{"lu_rn",    mk(5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1), LUO};
    tbl[4]  = '{"lu_rd",    mk(5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd20, 1'b1, 1'b1), LUO};
    tbl[5]  = '{"no_uses",  mk(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1), NORM};
    tbl[6]  = '{"not_load", mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0), NORM};
    tbl[7]  = '{"no_regwr", mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1), NORM};
    tbl[8]  = '{"br_taken", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1), FLSH};
    tbl[9]  = '{"br_lu",    mk(5'd9, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1), LUO};
    tbl[10] = '{"lu_mc",    mk(5'd1, 5'd6, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1), LUO};
    tbl[11] = '{"mismatch", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1), NORM};

    apply(idle, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    step("reset", idle, 1'b1, NORM);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].name, tbl[i].v, 1'b0, tbl[i].o);
      if (tbl[i].o[6] == 1'b0) step("after", idle, 1'b0, NORM);
    end

    // Load-use from clean state: one stall cycle, then normal with count 1.
    step("rst", idle, 1'b1, NORM);
    step("lu_seq", luv, 1'b0, LUO);
    step("lu_after", idle, 1'b0, NORM);

    // Branch priority: suppressed under LU, honoured the next cycle.
    step("br_lu2", tbl[9].v, 1'b0, LUO);
    step("br_ok", tbl[8].v, 1'b0, FLSH);

    // MUL: three busy cycles.
    step("rst", idle, 1'b1, NORM);
    step("mul_issue", mulv, 1'b0, NORM);
    for (int i = 0; i < 3; i++) step("mul_busy", idle, 1'b0, BUSYO);
    step("mul_done", idle, 1'b0, NORM);

    // LU together with MUL: stall first, issue next cycle.
    step("lumc", tbl[10].v, 1'b0, LUO);
    step("lumc_iss", mulv, 1'b0, NORM);
    for (int i = 0; i < 3; i++) step("lumc_busy", idle, 1'b0, BUSYO);
    step("lumc_done", idle, 1'b0, NORM);

    // Back-to-back SDIV; DEC holds the second one during the first's busy period.
    step("rst", idle, 1'b1, NORM);
    step("div1_iss", divv, 1'b0, NORM);
    for (int i = 0; i < 15; i++) step("div1_busy", divv, 1'b0, BUSYO);
    step("div2_iss", divv, 1'b0, NORM);
    for (int i = 0; i < 15; i++) step("div2_busy", idle, 1'b0, BUSYO);
    step("div_done", idle, 1'b0, NORM);

    // Reset on busy cycle 5 aborts the divide.
    step("rst", idle, 1'b1, NORM);
    step("div_iss", divv, 1'b0, NORM);
    for (int i = 0; i < 4; i++) step("div_busy", idle, 1'b0, BUSYO);
    step("div_rst", idle, 1'b1, NORM);
    step("post_rst", idle, 1'b0, NORM);
    step("post_rst2", idle, 1'b0, NORM);

    // Saturation of a 4-bit counter after 20 stalls.
    rst_s = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_lu", luv, 1'b0, LUO);
    checks++;
    if (s_stall !== 4'hF) begin
      errors++;
      $display("FAIL sat4 StallCycles: got %0d expected 15", s_stall);
    end
    $display("txn sat4         stall=%0d", s_stall);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
